// File: rtl/risc_pkg.sv
// Shared definitions for the operand stage: ALU op encodings and default widths.
package risc_pkg;

  localparam logic [1:0] ALU_AND  = 2'b00;
  localparam logic [1:0] ALU_OR   = 2'b01;
  localparam logic [1:0] ALU_ADD  = 2'b10;
  localparam logic [1:0] ALU_NAND = 2'b11;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 3;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, R0 hardwired to zero.
module reg_file
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr != ZERO) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = (raddr_a == ZERO) ? '0 : regs[raddr_a];
    rdata_b = (raddr_b == ZERO) ? '0 : regs[raddr_b];
  end

endmodule

// File: rtl/operand_stage.sv
// Decode-to-execute stage: resolves operands with EX/WB forwarding and holds one
// issued instruction for the ALU behind a valid/ready handshake.
module operand_stage
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [1:0]        InOp,
  input  logic [ADDR_W-1:0] InRs1,
  input  logic [ADDR_W-1:0] InRs2,
  input  logic [ADDR_W-1:0] InRd,
  input  logic              InUseImm,
  input  logic [DATA_W-1:0] InImm,
  input  logic              Flush,
  input  logic              FwdEn,
  input  logic [ADDR_W-1:0] FwdAddr,
  input  logic [DATA_W-1:0] FwdData,
  input  logic              WbEn,
  input  logic [ADDR_W-1:0] WbAddr,
  input  logic [DATA_W-1:0] WbData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] ALUInA,
  output logic [DATA_W-1:0] ALUInB,
  output logic [1:0]        ALUControlSignal,
  output logic [ADDR_W-1:0] OutRd
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W-1:0] res_a, res_b;
  logic [DATA_W-1:0] snoop_a, snoop_b;
  logic [ADDR_W-1:0] held_rs1, held_rs2;
  logic              held_use_imm;
  logic              accept;

  reg_file #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (WbEn),
    .waddr  (WbAddr),
    .wdata  (WbData),
    .raddr_a(InRs1),
    .raddr_b(InRs2),
    .rdata_a(rf_a),
    .rdata_b(rf_b)
  );

  assign InReady = !reset && !Flush && (!OutValid || OutReady);
  assign accept  = InValid && InReady;

  // EX bypass beats the same-cycle writeback, which beats the stored value.
  always_comb begin
    res_a = rf_a;
    if (InRs1 == ZERO)                       res_a = '0;
    else if (FwdEn && FwdAddr == InRs1)      res_a = FwdData;
    else if (WbEn && WbAddr == InRs1)        res_a = WbData;

    res_b = rf_b;
    if (InUseImm)                            res_b = InImm;
    else if (InRs2 == ZERO)                  res_b = '0;
    else if (FwdEn && FwdAddr == InRs2)      res_b = FwdData;
    else if (WbEn && WbAddr == InRs2)        res_b = WbData;
  end

  // A held entry keeps watching the bypass/writeback buses so a stall never
  // leaves it with a stale operand.
  always_comb begin
    snoop_a = ALUInA;
    if (held_rs1 != ZERO) begin
      if (FwdEn && FwdAddr == held_rs1)      snoop_a = FwdData;
      else if (WbEn && WbAddr == held_rs1)   snoop_a = WbData;
    end

    snoop_b = ALUInB;
    if (!held_use_imm && held_rs2 != ZERO) begin
      if (FwdEn && FwdAddr == held_rs2)      snoop_b = FwdData;
      else if (WbEn && WbAddr == held_rs2)   snoop_b = WbData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      OutValid         <= 1'b0;
      ALUInA           <= '0;
      ALUInB           <= '0;
      ALUControlSignal <= ALU_AND;
      OutRd            <= '0;
      held_rs1         <= '0;
      held_rs2         <= '0;
      held_use_imm     <= 1'b0;
    end else if (accept) begin
      OutValid         <= 1'b1;
      ALUInA           <= res_a;
      ALUInB           <= res_b;
      ALUControlSignal <= InOp;
      OutRd            <= InRd;
      held_rs1         <= InRs1;
      held_rs2         <= InRs2;
      held_use_imm     <= InUseImm;
    end else begin
      if (Flush || OutReady) OutValid <= 1'b0;
      if (OutValid) begin
        ALUInA <= snoop_a;
        ALUInB <= snoop_b;
      end
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Directed-vector bench for operand_stage with hand-computed expectations.
module tb_operand_stage;

  logic        clk;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic [1:0]  InOp;
  logic [2:0]  InRs1, InRs2, InRd;
  logic        InUseImm;
  logic [31:0] InImm;
  logic        Flush;
  logic        FwdEn;
  logic [2:0]  FwdAddr;
  logic [31:0] FwdData;
  logic        WbEn;
  logic [2:0]  WbAddr;
  logic [31:0] WbData;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] ALUInA, ALUInB;
  logic [1:0]  ALUControlSignal;
  logic [2:0]  OutRd;

  int checks   = 0;
  int failures = 0;

  operand_stage #(
    .DATA_W  (32),
    .NUM_REGS(8),
    .ADDR_W  (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .InValid         (InValid),
    .InReady         (InReady),
    .InOp            (InOp),
    .InRs1           (InRs1),
    .InRs2           (InRs2),
    .InRd            (InRd),
    .InUseImm        (InUseImm),
    .InImm           (InImm),
    .Flush           (Flush),
    .FwdEn           (FwdEn),
    .FwdAddr         (FwdAddr),
    .FwdData         (FwdData),
    .WbEn            (WbEn),
    .WbAddr          (WbAddr),
    .WbData          (WbData),
    .OutValid        (OutValid),
    .OutReady        (OutReady),
    .ALUInA          (ALUInA),
    .ALUInB          (ALUInB),
    .ALUControlSignal(ALUControlSignal),
    .OutRd           (OutRd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    InValid = 0; InOp = 2'b00; InRs1 = 0; InRs2 = 0; InRd = 0;
    InUseImm = 0; InImm = '0; Flush = 0;
    FwdEn = 0; FwdAddr = 0; FwdData = '0;
    WbEn = 0; WbAddr = 0; WbData = '0;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                           input logic [2:0] rd, input logic use_imm, input logic [31:0] imm);
    InValid = 1; InOp = op; InRs1 = rs1; InRs2 = rs2; InRd = rd;
    InUseImm = use_imm; InImm = imm;
  endtask

  task automatic wb_write(input logic [2:0] addr, input logic [31:0] data);
    WbEn = 1; WbAddr = addr; WbData = data;
    tick();
    WbEn = 0;
  endtask

  initial begin
    idle_inputs();
    OutReady = 1;
    reset = 1;
    tick();
    tick();
    check("rst_in_ready", InReady, 0);
    check("rst_out_valid", OutValid, 0);
    check("rst_a", ALUInA, 0);
    check("rst_b", ALUInB, 0);
    check("rst_ctrl", ALUControlSignal, 0);
    check("rst_rd", OutRd, 0);
    reset = 0;
    #1;
    check("in_ready_idle", InReady, 1);

    // 1: basic issue after writes
    wb_write(3'd1, 32'h0000_0005);
    wb_write(3'd2, 32'h0000_0003);
    set_instr(2'b10, 3'd1, 3'd2, 3'd3, 0, '0);
    tick();
    InValid = 0;
    check("t1_valid", OutValid, 1);
    check("t1_a", ALUInA, 32'h5);
    check("t1_b", ALUInB, 32'h3);
    check("t1_ctrl", ALUControlSignal, 2'b10);
    check("t1_rd", OutRd, 3'd3);
    tick();
    check("t1_drain", OutValid, 0);

    // 2: forward beats writeback; writeback still lands in the file
    set_instr(2'b00, 3'd4, 3'd0, 3'd1, 0, '0);
    FwdEn = 1; FwdAddr = 3'd4; FwdData = 32'hAAAA_0000;
    WbEn = 1; WbAddr = 3'd4; WbData = 32'h1234_5678;
    tick();
    FwdEn = 0; WbEn = 0;
    check("t2_a_fwd", ALUInA, 32'hAAAA_0000);
    check("t2_b_r0", ALUInB, 0);
    set_instr(2'b01, 3'd4, 3'd4, 3'd2, 0, '0);
    tick();
    InValid = 0;
    check("t2_rf4_a", ALUInA, 32'h1234_5678);
    check("t2_rf4_b", ALUInB, 32'h1234_5678);
    tick();

    // 3: R0 and immediate
    wb_write(3'd0, 32'hFFFF_FFFF);
    set_instr(2'b11, 3'd0, 3'd2, 3'd5, 1, 32'h0000_00F0);
    tick();
    InValid = 0;
    check("t3_a_r0", ALUInA, 0);
    check("t3_b_imm", ALUInB, 32'hF0);
    check("t3_ctrl", ALUControlSignal, 2'b11);
    check("t3_rd", OutRd, 3'd5);
    tick();

    // 4: stall with snoop, then delayed accept
    OutReady = 0;
    set_instr(2'b01, 3'd1, 3'd2, 3'd6, 0, '0);
    tick();
    InValid = 0;
    check("t4_held_valid", OutValid, 1);
    check("t4_held_b", ALUInB, 32'h3);
    #1;
    check("t4_in_ready_stall", InReady, 0);
    FwdEn = 1; FwdAddr = 3'd1; FwdData = 32'h0000_0077;
    tick();
    FwdEn = 0;
    check("t4_snoop_fwd_a", ALUInA, 32'h77);
    check("t4_snoop_fwd_b", ALUInB, 32'h3);
    WbEn = 1; WbAddr = 3'd2; WbData = 32'h0000_0009;
    tick();
    WbEn = 0;
    check("t4_snoop_wb_b", ALUInB, 32'h9);
    check("t4_snoop_wb_a", ALUInA, 32'h77);
    check("t4_still_valid", OutValid, 1);
    set_instr(2'b00, 3'd2, 3'd1, 3'd7, 0, '0);
    #1;
    check("t4_in_ready_2nd", InReady, 0);
    tick();
    check("t4_hold_ctrl", ALUControlSignal, 2'b01);
    check("t4_hold_rd", OutRd, 3'd6);
    check("t4_hold_valid", OutValid, 1);
    OutReady = 1;
    #1;
    check("t4_in_ready_rise", InReady, 1);
    tick();
    InValid = 0;
    check("t4_2nd_valid", OutValid, 1);
    check("t4_2nd_rd", OutRd, 3'd7);
    check("t4_2nd_ctrl", ALUControlSignal, 2'b00);
    check("t4_2nd_a", ALUInA, 32'h9);
    check("t4_2nd_b", ALUInB, 32'h5);
    tick();
    check("t4_drain", OutValid, 0);

    // 5: back-to-back stream
    for (int i = 1; i <= 4; i++) begin
      set_instr(2'b10, 3'd1, 3'd0, 3'(i), 1, 32'(i * 16));
      tick();
      check("t5_valid", OutValid, 1);
      check("t5_rd", OutRd, 32'(i));
      check("t5_b", ALUInB, 32'(i * 16));
    end
    InValid = 0;
    tick();
    check("t5_drain", OutValid, 0);

    // 6a: flush with held entry and pending input; file write still happens
    OutReady = 0;
    set_instr(2'b10, 3'd1, 3'd2, 3'd3, 0, '0);
    tick();
    check("t6_held", OutValid, 1);
    set_instr(2'b01, 3'd2, 3'd2, 3'd4, 0, '0);
    Flush = 1; OutReady = 1;
    WbEn = 1; WbAddr = 3'd5; WbData = 32'h0000_0055;
    #1;
    check("t6_flush_ready", InReady, 0);
    tick();
    Flush = 0; WbEn = 0; InValid = 0;
    check("t6_flush_valid", OutValid, 0);
    set_instr(2'b10, 3'd5, 3'd0, 3'd1, 0, '0);
    tick();
    InValid = 0;
    check("t6_flush_wb", ALUInA, 32'h55);
    tick();

    // 6b: reset while an entry is held
    OutReady = 0;
    set_instr(2'b10, 3'd1, 3'd2, 3'd3, 0, '0);
    tick();
    InValid = 0;
    check("t6_held2", OutValid, 1);
    reset = 1;
    tick();
    reset = 0;
    OutReady = 1;
    check("t6_rst_valid", OutValid, 0);
    set_instr(2'b10, 3'd1, 3'd2, 3'd3, 0, '0);
    tick();
    check("t6_rst_r1", ALUInA, 0);
    check("t6_rst_r2", ALUInB, 0);
    set_instr(2'b10, 3'd4, 3'd5, 3'd3, 0, '0);
    tick();
    InValid = 0;
    check("t6_rst_r4", ALUInA, 0);
    check("t6_rst_r5", ALUInB, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Decode-to-execute stage that sits directly upstream of the ALU and drives its ALUInA, ALUInB and ALUControlSignal inputs.
- Contains the architectural register file, with two read ports and one write port.
- Resolves operands with forwarding from the EX result and the writeback result.
- Holds one issued instruction in an output register, using a valid/ready handshake with stall and flush.

Parameters:
- DATA_W, 32, operand and register width.
- NUM_REGS, 8, register count; R0 reads as zero.
- ADDR_W, 3, register address width; must equal clog2(NUM_REGS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- InValid  in  1  decode presents an instruction.
- InReady  out  1  stage accepts this cycle.
- InOp  in  2  ALU op: 00 AND, 01 OR, 10 ADD, 11 NAND.
- InRs1, InRs2  in  ADDR_W  source registers.
- InRd  in  ADDR_W  destination register.
- InUseImm  in  1  B operand = InImm instead of Rs2.
- InImm  in  DATA_W  immediate, already extended.
- Flush  in  1  kill the held entry and refuse input.
- FwdEn, FwdAddr, FwdData  in  1/ADDR_W/DATA_W  EX-stage result bypass.
- WbEn, WbAddr, WbData  in  1/ADDR_W/DATA_W  register-file write port.
- OutValid  out  1  ALU operands valid.
- OutReady  in  1  downstream consumes.
- ALUInA, ALUInB  out  DATA_W  resolved operands.
- ALUControlSignal  out  2  registered InOp.
- OutRd  out  ADDR_W  registered InRd.

Behaviour:
- Reset values (synchronous, takes priority over all other actions):
  - every register-file entry = 0;
  - OutValid = 0; ALUInA = ALUInB = 0; ALUControlSignal = 00; OutRd = 0;
  - held Rs1/Rs2/UseImm = 0.
- InReady = !reset && !Flush && (!OutValid || OutReady). It is combinational and never depends on InValid.
- Accept = InValid && InReady. On an accepted edge:
  - all outputs load from resolved values;
  - OutValid = 1;
  - latency is exactly 1 cycle from accept to OutValid.
- Consume without a new accept (OutValid && OutReady && !Accept): OutValid = 0 next edge; data outputs keep their last value.
- Back-to-back: consume and accept in the same cycle keeps OutValid = 1, which gives full throughput.
- Operand resolution for address r, applied at accept:
  - if r == 0, result is 0;
  - else if FwdEn && FwdAddr == r, result is FwdData;
  - else if WbEn && WbAddr == r, result is WbData (write-through);
  - else result is regfile[r].
- A operand = resolve(InRs1). B operand = InUseImm ? InImm : resolve(InRs2).
- Held-entry snoop (OutValid && !Accept):
  - for each held source not replaced by an immediate and not 0: if FwdEn matches, load FwdData; else if WbEn matches, load WbData;
  - this keeps stalled operands coherent;
  - ALUControlSignal and OutRd never change while held.
- Register file:
  - written at the edge when WbEn && WbAddr != 0;
  - writes to R0 are ignored;
  - the FwdEn port never writes the file.
- Flush:
  - OutValid = 0 next edge;
  - InReady = 0 that cycle, so no accept occurs;
  - register-file writes still occur;
  - Flush together with OutReady is legal, and the result is OutValid = 0.
- Reset asserted mid-operation: the held entry is dropped and the register file is cleared on that edge.
- ALUInA/ALUInB are undefined-but-stable when OutValid = 0; verification checks them only when OutValid = 1.
- Handshake invariant: while OutValid && !OutReady, the outputs change only via snoop.

Decomposition:
- Shared package `risc_pkg` holds:
  - ALU op constants ALU_AND = 2'b00, ALU_OR = 2'b01, ALU_ADD = 2'b10, ALU_NAND = 2'b11;
  - DATA_W and ADDR_W defaults;
  - the ZERO_REG index.
- One sub-module, `reg_file`: NUM_REGS x DATA_W, two combinational read ports, one synchronous write port, and R0 forced to zero.
- Forwarding priority, the handshake and snoop logic stay in operand_stage.

Test Plan:
1. Basic issue and write-through:
   - After reset, WbEn writes R1 = 0x0000_0005 and R2 = 0x0000_0003.
   - Issue ADD R3, R1, R2 with OutReady = 1.
   - Next cycle: OutValid = 1, ALUInA = 5, ALUInB = 3, ALUControlSignal = 10, OutRd = 3.
2. Forwarding priority:
   - Issue with InRs1 = 4 while FwdEn (addr 4, 0xAAAA_0000) and WbEn (addr 4, 0x1234_5678) are both asserted.
   - ALUInA = 0xAAAA_0000, and regfile[4] = 0x1234_5678 afterwards.
3. R0 and immediate:
   - WbEn writes R0 = 0xFFFF_FFFF; then issue NAND with Rs1 = 0, InUseImm = 1, InImm = 0x0000_00F0.
   - ALUInA = 0, ALUInB = 0x0000_00F0, ALUControlSignal = 11.
4. Stall with snoop:
   - Hold OutReady = 0 with an entry where Rs2 = 2; the entry is held and InReady = 0.
   - Pulse WbEn (addr 2, 0x0000_0009).
   - ALUInB becomes 9 next edge, and OutValid stays 1 throughout.
   - A stalled second InValid is accepted only after OutReady rises.
5. Back-to-back throughput:
   - Stream 4 instructions with InValid = 1 and OutReady = 1 continuously.
   - 4 consecutive OutValid cycles, in order, with no bubbles.
6. Flush and mid-operation reset:
   - Flush with OutValid = 1 and InValid = 1: InReady = 0, and OutValid = 0 next edge.
   - Reset asserted while an entry is held: OutValid = 0 and all registers read 0 afterwards.
